// File: rtl/sparse_buffer_ctrl.sv
// Eight-entry ring-ordered sparse buffer controller.
// Entries are allocated in order at top_ptr and released out of order, either by index
// (free port) or from the head (pop port). bottom_ptr tracks the oldest valid entry and
// feeds the head outputs to an in-order consumer.
module sparse_buffer_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              alloc_valid_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    output logic              alloc_ready_o,
    output logic [2:0]        alloc_idx_o,
    input  logic              free_valid_i,
    input  logic [2:0]        free_idx_i,
    output logic              head_valid_o,
    output logic [2:0]        head_idx_o,
    output logic [DATA_W-1:0] head_data_o,
    input  logic              head_pop_i,
    output logic [3:0]        count_o,
    output logic              err_o
);

    logic [7:0]        entry_valid_q;
    logic [DATA_W-1:0] entry_data_q [8];
    logic [2:0]        top_ptr_q, top_ptr_d;
    logic [2:0]        bottom_ptr_q, bottom_ptr_d;
    logic              err_q, err_d;

    logic [7:0] valid_nxt;
    logic [7:0] free_clear, pop_clear, alloc_set;
    logic       alloc_fire, free_hit, pop_hit;
    logic [2:0] search_idx;
    logic       search_found;

    // A valid slot at top_ptr blocks allocation; there is no skipping over it.
    assign alloc_ready_o = ~entry_valid_q[top_ptr_q];
    assign alloc_idx_o   = top_ptr_q;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;

    assign head_valid_o = |entry_valid_q;
    assign head_idx_o   = bottom_ptr_q;
    assign head_data_o  = entry_data_q[bottom_ptr_q];
    assign err_o        = err_q;

    // Set/clear masks, next valid vector, next top pointer and error detection.
    always_comb begin
        free_hit   = free_valid_i & entry_valid_q[free_idx_i];
        pop_hit    = head_pop_i & head_valid_o;
        free_clear = free_hit   ? (8'b1 << free_idx_i)   : 8'b0;
        pop_clear  = pop_hit    ? (8'b1 << bottom_ptr_q) : 8'b0;
        alloc_set  = alloc_fire ? (8'b1 << top_ptr_q)    : 8'b0;
        // Free and pop on the same index merge into one clear; alloc never
        // targets a cleared slot because it needs the slot invalid now.
        valid_nxt  = (entry_valid_q & ~free_clear & ~pop_clear) | alloc_set;
        top_ptr_d  = top_ptr_q + {2'b00, alloc_fire};
        err_d      = (free_valid_i & ~entry_valid_q[free_idx_i]) |
                     (head_pop_i & ~head_valid_o);
    end

    // Circular search from bottom_ptr for the oldest entry still valid next cycle;
    // when nothing survives, park on the next allocation slot.
    always_comb begin
        bottom_ptr_d = top_ptr_d;
        search_found = 1'b0;
        search_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            search_idx = bottom_ptr_q + 3'(k);
            if (!search_found && valid_nxt[search_idx]) begin
                bottom_ptr_d = search_idx;
                search_found = 1'b1;
            end
        end
    end

    // Population count of the registered valid vector.
    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, entry_valid_q[i]};
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            entry_valid_q <= 8'b0;
            top_ptr_q     <= 3'd0;
            bottom_ptr_q  <= 3'd0;
            err_q         <= 1'b0;
        end else begin
            entry_valid_q <= valid_nxt;
            top_ptr_q     <= top_ptr_d;
            bottom_ptr_q  <= bottom_ptr_d;
            err_q         <= err_d;
        end
    end

    // Payload storage; not reset since contents only matter while the entry is valid.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            entry_data_q[top_ptr_q] <= alloc_data_i;
        end
    end

endmodule

// File: tb/tb_sparse_buffer_ctrl.sv
// Self-checking bench for sparse_buffer_ctrl: a reference model predicts the visible
// outputs after every clock, pushes them to a scoreboard queue, and each scenario task
// pops and compares them, alongside directed checks of the expected values.
module tb_sparse_buffer_ctrl;

    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          alloc_valid_i;
    logic [DW-1:0] alloc_data_i;
    logic          alloc_ready_o;
    logic [2:0]    alloc_idx_o;
    logic          free_valid_i;
    logic [2:0]    free_idx_i;
    logic          head_valid_o;
    logic [2:0]    head_idx_o;
    logic [DW-1:0] head_data_o;
    logic          head_pop_i;
    logic [3:0]    count_o;
    logic          err_o;

    sparse_buffer_ctrl #(.DATA_W(DW)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_data_i  (alloc_data_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_idx_o   (alloc_idx_o),
        .free_valid_i  (free_valid_i),
        .free_idx_i    (free_idx_i),
        .head_valid_o  (head_valid_o),
        .head_idx_o    (head_idx_o),
        .head_data_o   (head_data_o),
        .head_pop_i    (head_pop_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          ready;
        logic [2:0]    aidx;
        logic          hv;
        logic [2:0]    hidx;
        logic [DW-1:0] hdata;
        logic [3:0]    cnt;
        logic          err;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state.
    logic [7:0]    m_valid;
    logic [DW-1:0] m_data [8];
    logic [2:0]    m_top;
    logic [2:0]    m_bottom;
    logic          m_err;

    // Head data is only meaningful while something is valid.
    function automatic obs_t dut_obs();
        obs_t o;
        o.ready = alloc_ready_o;
        o.aidx  = alloc_idx_o;
        o.hv    = head_valid_o;
        o.hidx  = head_idx_o;
        o.hdata = head_valid_o ? head_data_o : '0;
        o.cnt   = count_o;
        o.err   = err_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.ready = !m_valid[m_top];
        o.aidx  = m_top;
        o.hv    = |m_valid;
        o.hidx  = m_bottom;
        o.hdata = o.hv ? m_data[m_bottom] : '0;
        o.cnt   = 4'($countones(m_valid));
        o.err   = m_err;
        return o;
    endfunction

    task automatic model_reset();
        m_valid  = 8'h00;
        m_top    = 3'd0;
        m_bottom = 3'd0;
        m_err    = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        #2;
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // Drive one cycle of stimulus, advance the model, push its prediction.
    task automatic step(input logic av, input logic [DW-1:0] ad, input logic fv,
                        input logic [2:0] fi, input logic pop);
        logic       ready, fire, hv;
        logic [7:0] nv;
        logic [2:0] ntop, nbot;
        logic       nerr, found;
        logic [DW-1:0] nd;
        alloc_valid_i = av;
        alloc_data_i  = ad;
        free_valid_i  = fv;
        free_idx_i    = fi;
        head_pop_i    = pop;
        ready = !m_valid[m_top];
        fire  = av && ready;
        hv    = (m_valid != 8'h00);
        nerr  = (fv && !m_valid[fi]) || (pop && !hv);
        nv    = m_valid;
        if (fv && m_valid[fi]) nv[fi] = 1'b0;
        if (pop && hv) nv[m_bottom] = 1'b0;
        nd = m_data[m_top];
        if (fire) begin
            nv[m_top] = 1'b1;
            nd = ad;
        end
        ntop  = fire ? m_top + 3'd1 : m_top;
        nbot  = ntop;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found && nv[3'(m_bottom + 3'(k))]) begin
                nbot  = 3'(m_bottom + 3'(k));
                found = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        m_data[m_top] = nd;
        m_valid  = nv;
        m_top    = ntop;
        m_bottom = nbot;
        m_err    = nerr;
        alloc_valid_i = 1'b0;
        free_valid_i  = 1'b0;
        head_pop_i    = 1'b0;
        exp_q.push_back(model_obs());
    endtask

    task automatic test_reset();
        obs_t got, want;
        want = '{ready: 1'b1, aidx: 3'd0, hv: 1'b0, hidx: 3'd0, hdata: '0, cnt: 4'd0,
                 err: 1'b0};
        rst_n_i = 1'b0;
        #12;
        model_reset();
        got = dut_obs();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", got, want);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_fill();
        obs_t got, want;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (alloc_idx_o !== 3'(i)) begin
                n_bad++;
                $display("FAIL fill_alloc_idx: got %0d want %0d", alloc_idx_o, i);
            end
            step(1'b1, 32'h10 + 32'(i), 1'b0, 3'd0, 1'b0);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL fill_sb: got %h want %h", got, want);
            end
        end
        n_cmp++;
        if ({alloc_ready_o, count_o, head_idx_o} !== {1'b0, 4'd8, 3'd0}) begin
            n_bad++;
            $display("FAIL full_state: got rdy=%0b cnt=%0d hidx=%0d want 0 8 0",
                     alloc_ready_o, count_o, head_idx_o);
        end
        n_cmp++;
        if (head_data_o !== 32'h10) begin
            n_bad++;
            $display("FAIL full_head_data: got %h want 10", head_data_o);
        end
    endtask

    task automatic test_free_out_of_order();
        obs_t got, want;
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, '0, 1'b1, 3'(i), 1'b0);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL free_sb: got %h want %h", got, want);
            end
            n_cmp++;
            if ({head_idx_o, alloc_ready_o} !== {3'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL free_head_hold: got hidx=%0d rdy=%0b want 0 0",
                         head_idx_o, alloc_ready_o);
            end
        end
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL pop_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({head_idx_o, head_data_o, count_o, alloc_ready_o} !==
            {3'd4, 32'h14, 4'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL pop_skip_holes: got hidx=%0d data=%h cnt=%0d rdy=%0b want 4 14 4 1",
                     head_idx_o, head_data_o, count_o, alloc_ready_o);
        end
    endtask

    task automatic test_wrap();
        obs_t got, want;
        // alloc idx 0, then pop 4 and 5: leaves valid {6,7,0}, bottom 6
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b1, 32'hA0, 1'b0, 3'd0, 1'b0);
            else        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL wrap_setup_sb: got %h want %h", got, want);
            end
        end
        n_cmp++;
        if ({head_idx_o, count_o} !== {3'd6, 4'd3}) begin
            n_bad++;
            $display("FAIL wrap_setup: got hidx=%0d cnt=%0d want 6 3", head_idx_o, count_o);
        end
        step(1'b0, '0, 1'b1, 3'd7, 1'b0);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL wrap_free_sb: got %h want %h", got, want);
        end
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL wrap_pop_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({head_idx_o, head_data_o} !== {3'd0, 32'hA0}) begin
            n_bad++;
            $display("FAIL wrap_head: got hidx=%0d data=%h want 0 a0", head_idx_o, head_data_o);
        end
    endtask

    task automatic test_empty();
        obs_t got, want;
        // valid {0} top 1 -> alloc 1..5, pop 0..4, leaving only idx 5 with top 6
        for (int i = 0; i < 10; i++) begin
            if (i < 5) step(1'b1, 32'hB1 + 32'(i), 1'b0, 3'd0, 1'b0);
            else       step(1'b0, '0, 1'b0, 3'd0, 1'b1);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL empty_setup_sb: got %h want %h", got, want);
            end
        end
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL empty_pop_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({head_valid_o, head_idx_o, count_o} !== {1'b0, 3'd6, 4'd0}) begin
            n_bad++;
            $display("FAIL empty_state: got hv=%0b hidx=%0d cnt=%0d want 0 6 0",
                     head_valid_o, head_idx_o, count_o);
        end
        step(1'b1, 32'hC6, 1'b0, 3'd0, 1'b0);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL empty_alloc_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({head_valid_o, head_idx_o, head_data_o} !== {1'b1, 3'd6, 32'hC6}) begin
            n_bad++;
            $display("FAIL empty_refill: got hv=%0b hidx=%0d data=%h want 1 6 c6",
                     head_valid_o, head_idx_o, head_data_o);
        end
    endtask

    task automatic test_same_cycle();
        obs_t got, want;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'hD0 + 32'(i), 1'b0, 3'd0, 1'b0);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL same_setup_sb: got %h want %h", got, want);
            end
        end
        // alloc idx 2 while free and pop both hit head idx 0
        step(1'b1, 32'hD2, 1'b1, 3'd0, 1'b1);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL same_cycle_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({err_o, count_o, head_idx_o, head_data_o, alloc_idx_o} !==
            {1'b0, 4'd2, 3'd1, 32'hD1, 3'd3}) begin
            n_bad++;
            $display("FAIL same_cycle: got err=%0b cnt=%0d hidx=%0d data=%h aidx=%0d want 0 2 1 d1 3",
                     err_o, count_o, head_idx_o, head_data_o, alloc_idx_o);
        end
    endtask

    task automatic test_errors();
        obs_t got, want;
        step(1'b0, '0, 1'b1, 3'd3, 1'b0);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL bad_free_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if ({err_o, count_o, head_idx_o} !== {1'b1, 4'd2, 3'd1}) begin
            n_bad++;
            $display("FAIL bad_free: got err=%0b cnt=%0d hidx=%0d want 1 2 1",
                     err_o, count_o, head_idx_o);
        end
        step(1'b0, '0, 1'b0, 3'd0, 1'b0);
        got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL bad_free_clear_sb: got %h want %h", got, want);
        end
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse_width: got %0b want 0", err_o);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        // distinct alloc 3, free 2, pop 1; then pop 3 to empty; then pop while empty; idle
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       step(1'b1, 32'hE3, 1'b1, 3'd2, 1'b1);
                1, 2:    step(1'b0, '0, 1'b0, 3'd0, 1'b1);
                default: step(1'b0, '0, 1'b0, 3'd0, 1'b0);
            endcase
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL b2b_sb[%0d]: got %h want %h", i, got, want);
            end
            if (i == 0) begin
                n_cmp++;
                if ({count_o, head_idx_o, head_data_o, err_o} !== {4'd1, 3'd3, 32'hE3, 1'b0}) begin
                    n_bad++;
                    $display("FAIL triple_op: got cnt=%0d hidx=%0d data=%h err=%0b want 1 3 e3 0",
                             count_o, head_idx_o, head_data_o, err_o);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({err_o, head_valid_o, head_idx_o} !== {1'b1, 1'b0, 3'd4}) begin
                    n_bad++;
                    $display("FAIL pop_empty: got err=%0b hv=%0b hidx=%0d want 1 0 4",
                             err_o, head_valid_o, head_idx_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, want;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hF0 + 32'(i), 1'b0, 3'd0, 1'b0);
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL mid_setup_sb: got %h want %h", got, want);
            end
        end
        // Assert reset between clock edges; outputs must clear without a clock.
        rst_n_i = 1'b0;
        #1;
        model_reset();
        got = dut_obs();
        want = '{ready: 1'b1, aidx: 3'd0, hv: 1'b0, hidx: 3'd0, hdata: '0, cnt: 4'd0,
                 err: 1'b0};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", got, want);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_random();
        obs_t got, want;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 30),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 25));
            got = dut_obs(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random_sb[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        alloc_valid_i = 1'b0;
        alloc_data_i  = '0;
        free_valid_i  = 1'b0;
        free_idx_i    = 3'd0;
        head_pop_i    = 1'b0;
        test_reset();
        test_fill();
        test_free_out_of_order();
        test_wrap();
        test_empty();
        test_same_cycle();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
